// File: rtl/tx_udp.sv
// rtl/tx_udp.sv - UDP transmit framer: 8-byte header (checksum 0) followed by payload bytes
// Header bytes come from latched fields; payload is pulled with a registered request.
module tx_udp #(
  parameter int OCT = 8,
  parameter logic [2*OCT-1:0] MAX_LEN = 16'd1472
) (
  input  logic             TX_CLK,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [2*OCT-1:0] tx_src_port,
  input  logic [2*OCT-1:0] tx_dst_port,
  input  logic [2*OCT-1:0] tx_len,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_err,
  output logic             tx_udp_ready,
  input  logic             tx_udp_data_v,
  input  logic [OCT-1:0]   tx_udp_data,
  output logic             tx_data_v,
  output logic [OCT-1:0]   tx_data
);
  localparam int W = 2 * OCT;

  typedef enum logic [2:0] {IDLE, SRC_PORT, DST_PORT, DATA_LEN, CHECKSUM, UDP_DATA} state_t;

  state_t         state, state_n;
  logic           lo_byte, lo_byte_n;
  logic [W-1:0]   src, src_n, dst, dst_n, len, len_n, cnt, cnt_n;
  logic           busy_n, done_n, err_n, ready_n, data_v_n;
  logic [OCT-1:0] data_n;
  logic [W-1:0]   udp_len, cnt_inc;
  logic           payload_step;

  assign udp_len = len + W'(8);
  assign cnt_inc = cnt + W'(1);
  // The second checksum byte is also the first payload request cycle (or the end for N=0).
  assign payload_step = (state == CHECKSUM && lo_byte) || (state == UDP_DATA);

  always_comb begin
    state_n   = state;
    lo_byte_n = lo_byte;
    src_n     = src;
    dst_n     = dst;
    len_n     = len;
    cnt_n     = cnt;
    busy_n    = tx_busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    ready_n   = 1'b0;
    data_v_n  = 1'b0;
    data_n    = tx_data;

    case (state)
      IDLE: begin
        if (tx_start) begin
          if (tx_len <= MAX_LEN) begin
            src_n     = tx_src_port;
            dst_n     = tx_dst_port;
            len_n     = tx_len;
            cnt_n     = '0;
            lo_byte_n = 1'b0;
            busy_n    = 1'b1;
            data_v_n  = 1'b1;
            data_n    = tx_src_port[W-1:OCT];
            state_n   = SRC_PORT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SRC_PORT: begin
        data_v_n  = 1'b1;
        lo_byte_n = ~lo_byte;
        if (!lo_byte) data_n = src[OCT-1:0];
        else begin
          data_n  = dst[W-1:OCT];
          state_n = DST_PORT;
        end
      end
      DST_PORT: begin
        data_v_n  = 1'b1;
        lo_byte_n = ~lo_byte;
        if (!lo_byte) data_n = dst[OCT-1:0];
        else begin
          data_n  = udp_len[W-1:OCT];
          state_n = DATA_LEN;
        end
      end
      DATA_LEN: begin
        data_v_n  = 1'b1;
        lo_byte_n = ~lo_byte;
        if (!lo_byte) data_n = udp_len[OCT-1:0];
        else begin
          data_n  = '0;
          state_n = CHECKSUM;
        end
      end
      CHECKSUM: begin
        if (!lo_byte) begin
          data_v_n  = 1'b1;
          data_n    = '0;
          lo_byte_n = 1'b1;
          ready_n   = (len != '0);
        end
      end
      default: ;
    endcase

    if (payload_step) begin
      lo_byte_n = 1'b0;
      if (tx_udp_ready && tx_udp_data_v) begin
        data_v_n = 1'b1;
        data_n   = tx_udp_data;
        cnt_n    = cnt_inc;
        ready_n  = (cnt_inc < len);
        state_n  = UDP_DATA;
      end else begin
        // Either the last byte is out (done) or upstream missed a request (underrun).
        err_n   = tx_udp_ready;
        done_n  = ~tx_udp_ready;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      state        <= IDLE;
      lo_byte      <= 1'b0;
      src          <= '0;
      dst          <= '0;
      len          <= '0;
      cnt          <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
      tx_udp_ready <= 1'b0;
      tx_data_v    <= 1'b0;
      tx_data      <= '0;
    end else begin
      state        <= state_n;
      lo_byte      <= lo_byte_n;
      src          <= src_n;
      dst          <= dst_n;
      len          <= len_n;
      cnt          <= cnt_n;
      tx_busy      <= busy_n;
      tx_done      <= done_n;
      tx_err       <= err_n;
      tx_udp_ready <= ready_n;
      tx_data_v    <= data_v_n;
      tx_data      <= data_n;
    end
  end
endmodule

// File: tb/tb_tx_udp.sv
// tb/tb_tx_udp.sv - self-checking bench for tx_udp against a per-cycle frame model
// Expected bytes and pulse cycles are derived from the frame layout and cycle numbering.
module tb_tx_udp;
  logic        TX_CLK = 1'b0;
  logic        rst, tx_start;
  logic [15:0] tx_src_port, tx_dst_port, tx_len;
  logic        tx_busy, tx_done, tx_err, tx_udp_ready, tx_udp_data_v, tx_data_v;
  logic [7:0]  tx_udp_data, tx_data;
  int tests = 0;
  int failed = 0;

  always #5 TX_CLK = ~TX_CLK;

  tx_udp dut (
    .TX_CLK(TX_CLK), .rst(rst), .tx_start(tx_start),
    .tx_src_port(tx_src_port), .tx_dst_port(tx_dst_port), .tx_len(tx_len),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .tx_udp_ready(tx_udp_ready), .tx_udp_data_v(tx_udp_data_v), .tx_udp_data(tx_udp_data),
    .tx_data_v(tx_data_v), .tx_data(tx_data)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge TX_CLK);
    @(negedge TX_CLK);
  endtask

  task automatic idle_inputs();
    tx_start      = 1'b0;
    tx_src_port   = 16'($urandom);
    tx_dst_port   = 16'($urandom);
    tx_len        = 16'($urandom);
    tx_udp_data_v = 1'($urandom_range(0, 1));
    tx_udp_data   = 8'($urandom);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".busy"}, 16'(tx_busy), 16'd0);
    chk({tag, ".v"}, 16'(tx_data_v), 16'd0);
    chk({tag, ".rdy"}, 16'(tx_udp_ready), 16'd0);
    chk({tag, ".done"}, 16'(tx_done), 16'd0);
    chk({tag, ".err"}, 16'(tx_err), 16'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      step();
      check_quiet("idle");
    end
  endtask

  task automatic reject(input logic [15:0] len);
    idle_inputs();
    tx_start = 1'b1;
    tx_len   = len;
    step();
    chk("rej.err", 16'(tx_err), 16'd1);
    chk("rej.busy", 16'(tx_busy), 16'd0);
    chk("rej.v", 16'(tx_data_v), 16'd0);
    idle(2);
  endtask

  // Runs one frame starting in the current cycle (cycle 0). drop: payload request index
  // left unserved (-1 none); mid: cycle of an ignored tx_start; rst_at: cycle rst is high.
  // Returns after checking the completion cycle so the caller may start back-to-back.
  task automatic run_frame(input logic [15:0] src, input logic [15:0] dst, input int len,
                           input int drop, input int mid, input int rst_at);
    logic [7:0]  hdr [8];
    logic [7:0]  pay [$];
    logic [15:0] ulen;
    int m, e, rdy_last;
    ulen = 16'(len + 8);
    hdr = '{src[15:8], src[7:0], dst[15:8], dst[7:0], ulen[15:8], ulen[7:0], 8'h00, 8'h00};
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    m        = (drop >= 0) ? drop : len;
    e        = 9 + m;
    rdy_last = (drop >= 0) ? 8 + drop : 7 + len;

    idle_inputs();
    tx_start    = 1'b1;
    tx_src_port = src;
    tx_dst_port = dst;
    tx_len      = 16'(len);
    step();
    for (int c = 1; c <= e; c++) begin
      if (rst_at >= 0 && c == rst_at + 1) begin
        check_quiet("rst");
        chk("rst.data", 16'(tx_data), 16'd0);
        rst = 1'b0;
        return;
      end
      chk("v", 16'(tx_data_v), 16'(c <= 8 + m));
      chk("busy", 16'(tx_busy), 16'(c <= 8 + m));
      chk("rdy", 16'(tx_udp_ready), 16'(c >= 8 && c <= rdy_last));
      chk("done", 16'(tx_done), 16'(c == e && drop < 0));
      chk("err", 16'(tx_err), 16'(c == e && drop >= 0));
      if (c <= 8) chk("hdr", 16'(tx_data), 16'(hdr[c-1]));
      else if (c <= 8 + m) chk("pay", 16'(tx_data), 16'(pay[c-9]));
      if (c == e) break;
      idle_inputs();
      tx_start = (c == mid);
      tx_len   = 16'($urandom_range(0, 20));
      rst      = (c == rst_at);
      if (c >= 8 && c <= rdy_last) begin
        tx_udp_data_v = !(drop >= 0 && c == 8 + drop);
        if (tx_udp_data_v) tx_udp_data = pay[c-8];
      end
      step();
    end
    tx_start = 1'b0;
  endtask

  initial begin
    int len, drop;
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    check_quiet("reset");
    chk("reset.data", 16'(tx_data), 16'd0);
    rst = 1'b0;
    idle(1);

    run_frame(16'h1234, 16'h0050, 4, -1, -1, -1);
    idle(2);
    run_frame(16'($urandom), 16'($urandom), 0, -1, -1, -1);
    idle(1);
    reject(16'd1473);
    run_frame(16'($urandom), 16'($urandom), 1472, -1, -1, -1);
    idle(1);
    run_frame(16'($urandom), 16'($urandom), 6, 2, -1, -1);
    idle(1);
    run_frame(16'($urandom), 16'($urandom), 5, -1, -1, -1);
    run_frame(16'hAAAA, 16'h5555, 5, -1, 3, -1);
    run_frame(16'($urandom), 16'($urandom), 3, -1, -1, -1);
    run_frame(16'($urandom), 16'($urandom), 0, -1, 5, -1);
    idle(1);
    run_frame(16'($urandom), 16'($urandom), 10, -1, -1, 12);
    idle(2);
    run_frame(16'($urandom), 16'($urandom), 3, -1, -1, -1);
    idle(1);

    for (int i = 0; i < 10; i++) begin
      len  = $urandom_range(0, 20);
      drop = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run_frame(16'($urandom), 16'($urandom), len, drop, -1, -1);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
